// File: rtl/button_led_pkg.sv
// Shared encodings for the two-button / two-LED front end.
package button_led_pkg;

  // LED mode, advanced by one step on every debounced press.
  typedef enum logic [1:0] {
    MODE_OFF        = 2'd0,
    MODE_ON         = 2'd1,
    MODE_BLINK_SLOW = 2'd2,
    MODE_BLINK_FAST = 2'd3
  } mode_e;

  // Board-level polarities: LEDs and buttons are both active-low.
  localparam logic LED_ON      = 1'b0;
  localparam logic LED_OFF     = 1'b1;
  localparam logic BTN_PRESSED = 1'b0;

  // Blink phase value for the lit half-period.
  localparam logic PHASE_LIT = 1'b1;

  // Mode sequence OFF -> ON -> BLINK_SLOW -> BLINK_FAST -> OFF.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:        return MODE_ON;
      MODE_ON:         return MODE_BLINK_SLOW;
      MODE_BLINK_SLOW: return MODE_BLINK_FAST;
      default:         return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: two-flop synchroniser, saturating-free debounce
// counter, debounced level and a single-cycle press pulse on 1->0 flips.
module button_debounce
  import button_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          sync_out;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          mismatch;
  logic          flip;

  // Two-flop synchroniser for the asynchronous raw button level.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, like real hardware.
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], raw};
  end

  assign sync_out = sync_q[1];
  assign mismatch = (sync_out != level_q);
  assign flip     = mismatch && (cnt_q == CNT_LAST);

  // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing
  // samples; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= ~BTN_PRESSED;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      press <= flip && (sync_out == BTN_PRESSED);
      if (flip) begin
        level_q <= sync_out;
        cnt_q   <= '0;
      end else if (mismatch) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/button_led_sequencer.sv
// Two independent button -> LED-mode channels. Each debounced press steps
// the channel's mode; a blink engine and an LED register drive the LED.
module button_led_sequencer
  import button_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int SLOW_HALF       = 13500000,
  parameter int FAST_HALF       = 3375000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       switch1,
  input  logic       switch2,
  output logic       led1,
  output logic       led2,
  output logic       press1,
  output logic       press2,
  output logic [1:0] mode1,
  output logic [1:0] mode2
);

  localparam int HALF_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int BW       = $clog2(HALF_MAX);
  localparam logic [BW-1:0] SLOW_LAST = BW'(SLOW_HALF - 1);
  localparam logic [BW-1:0] FAST_LAST = BW'(FAST_HALF - 1);

  logic [1:0]      raw_w;
  logic [1:0]      press_w;
  logic [1:0]      led_w;
  logic [1:0][1:0] mode_w;

  assign raw_w = {switch2, switch1};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    mode_e         mode_q;
    mode_e         mode_d;
    logic [BW-1:0] blink_cnt_q;
    logic          phase_q;
    logic          half_end;
    logic          led_q;

    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_w[ch]),
      .press(press_w[ch])
    );

    // Next mode: step once per press, otherwise hold.
    always_comb begin
      // NOTE: default first so every path assigns mode_d and no latch forms.
      mode_d = mode_q;
      if (press_w[ch]) mode_d = next_mode(mode_q);
    end

    // Mode state register.
    always_ff @(posedge clk) begin
      if (rst) mode_q <= MODE_OFF;
      else     mode_q <= mode_d;
    end

    assign half_end = ((mode_q == MODE_BLINK_SLOW) && (blink_cnt_q == SLOW_LAST)) ||
                      ((mode_q == MODE_BLINK_FAST) && (blink_cnt_q == FAST_LAST));

    // Blink engine: restart lit on a mode change, toggle phase each half-period.
    always_ff @(posedge clk) begin
      if (rst || press_w[ch]) begin
        blink_cnt_q <= '0;
        phase_q     <= PHASE_LIT;
      end else if (mode_q == MODE_BLINK_SLOW || mode_q == MODE_BLINK_FAST) begin
        if (half_end) begin
          blink_cnt_q <= '0;
          phase_q     <= ~phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end else begin
        blink_cnt_q <= '0;
      end
    end

    // LED register: follows mode and phase one cycle later.
    always_ff @(posedge clk) begin
      if (rst) begin
        led_q <= LED_OFF;
      end else begin
        case (mode_q)
          MODE_OFF: led_q <= LED_OFF;
          MODE_ON:  led_q <= LED_ON;
          default:  led_q <= (phase_q == PHASE_LIT) ? LED_ON : LED_OFF;
        endcase
      end
    end

    assign mode_w[ch] = mode_q;
    assign led_w[ch]  = led_q;
  end

  assign led1   = led_w[0];
  assign led2   = led_w[1];
  assign press1 = press_w[0];
  assign press2 = press_w[1];
  assign mode1  = mode_w[0];
  assign mode2  = mode_w[1];

endmodule

// File: tb/tb_button_led_sequencer.sv
// Directed bench for button_led_sequencer with short debounce/blink periods.
module tb_button_led_sequencer;

  logic       clk;
  logic       rst;
  logic       switch1;
  logic       switch2;
  logic       led1;
  logic       led2;
  logic       press1;
  logic       press2;
  logic [1:0] mode1;
  logic [1:0] mode2;

  int tests_run;
  int tests_failed;

  button_led_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .SLOW_HALF      (8),
    .FAST_HALF      (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .switch1(switch1),
    .switch2(switch2),
    .led1   (led1),
    .led2   (led2),
    .press1 (press1),
    .press2 (press2),
    .mode1  (mode1),
    .mode2  (mode2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    switch1 = 1'b1;
    switch2 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Press the selected buttons (held) and step 6 edges; the pulse must
  // appear only on the last of them (edge 5 counted from 0).
  task automatic press_ch(input logic p1, input logic p2, input string name);
    logic [1:0] exp;
    if (p1) switch1 = 1'b0;
    if (p2) switch2 = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      tick();
      exp = (e == 5) ? {p1, p2} : 2'b00;
      tests_run++;
      if ({press1, press2} !== exp) begin
        tests_failed++;
        $display("FAIL %s edge %0d: press={%b,%b} expected %b", name, e, press1, press2, exp);
      end
    end
  endtask

  // Release both buttons and wait for the debounced release; no pulse allowed.
  task automatic release_all(input string name);
    logic seen;
    seen    = 1'b0;
    switch1 = 1'b1;
    switch2 = 1'b1;
    repeat (10) begin
      tick();
      if (press1 || press2) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: press pulse seen on release, expected none", name);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      tests_run++;
      if ({led1, led2, press1, press2, mode1, mode2} !== 8'b1100_0000) begin
        tests_failed++;
        $display("FAIL reset_idle cycle %0d: led=%b%b press=%b%b mode=%0d/%0d expected led=11 press=00 mode=0/0",
                 i, led1, led2, press1, press2, mode1, mode2);
      end
    end
  endtask

  task automatic test_press_latency();
    do_reset();
    switch1 = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      tests_run++;
      if (press1 !== (e == 5)) begin
        tests_failed++;
        $display("FAIL latency_press1 edge %0d: got %b expected %b", e, press1, (e == 5));
      end
      if (e == 6 || e == 5) begin
        tests_run++;
        if (mode1 !== ((e == 6) ? 2'd1 : 2'd0)) begin
          tests_failed++;
          $display("FAIL latency_mode1 edge %0d: got %0d expected %0d", e, mode1, (e == 6) ? 1 : 0);
        end
      end
      tests_run++;
      if (led1 !== ((e == 7) ? 1'b0 : 1'b1)) begin
        tests_failed++;
        $display("FAIL latency_led1 edge %0d: got %b expected %b", e, led1, (e == 7) ? 1'b0 : 1'b1);
      end
      tests_run++;
      if ({press2, mode2, led2} !== 4'b0001) begin
        tests_failed++;
        $display("FAIL latency_ch2_idle edge %0d: press2=%b mode2=%0d led2=%b expected 0/0/1",
                 e, press2, mode2, led2);
      end
    end
    release_all("latency_release");
    tests_run++;
    if (mode1 !== 2'd1) begin
      tests_failed++;
      $display("FAIL latency_mode_after_release: got %0d expected 1", mode1);
    end
  endtask

  // Raw low for 3 samples, high for 1, then low: only the final run counts.
  task automatic test_bounce();
    do_reset();
    for (int e = 0; e <= 11; e++) begin
      switch1 = (e == 3) ? 1'b1 : 1'b0;
      tick();
      tests_run++;
      if (press1 !== (e == 9)) begin
        tests_failed++;
        $display("FAIL bounce_press1 edge %0d: got %b expected %b", e, press1, (e == 9));
      end
    end
    tests_run++;
    if (mode1 !== 2'd1) begin
      tests_failed++;
      $display("FAIL bounce_mode1: got %0d expected 1", mode1);
    end
    release_all("bounce_release");
  endtask

  task automatic test_blink();
    logic exp;
    do_reset();
    press_ch(1'b1, 1'b0, "blink_press_a");
    release_all("blink_release_a");
    press_ch(1'b1, 1'b0, "blink_press_b");
    // Held through the slow blink: 8 lit, 8 dark, 8 lit.
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 1) begin
        tests_run++;
        if (mode1 !== 2'd2) begin
          tests_failed++;
          $display("FAIL blink_slow_mode: got %0d expected 2", mode1);
        end
      end else begin
        exp = (((i - 2) / 8) % 2 == 1) ? 1'b1 : 1'b0;
        tests_run++;
        if (led1 !== exp) begin
          tests_failed++;
          $display("FAIL blink_slow_led1 step %0d: got %b expected %b", i, led1, exp);
        end
      end
    end
    release_all("blink_release_b");
    press_ch(1'b1, 1'b0, "blink_press_c");
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 1) begin
        tests_run++;
        if (mode1 !== 2'd3) begin
          tests_failed++;
          $display("FAIL blink_fast_mode: got %0d expected 3", mode1);
        end
      end else begin
        exp = (((i - 2) / 2) % 2 == 1) ? 1'b1 : 1'b0;
        tests_run++;
        if (led1 !== exp) begin
          tests_failed++;
          $display("FAIL blink_fast_led1 step %0d: got %b expected %b", i, led1, exp);
        end
      end
    end
    release_all("blink_release_c");
    press_ch(1'b1, 1'b0, "blink_press_d");
    tick();
    tests_run++;
    if (mode1 !== 2'd0) begin
      tests_failed++;
      $display("FAIL wrap_mode1: got %0d expected 0", mode1);
    end
    repeat (3) begin
      tick();
      tests_run++;
      if (led1 !== 1'b1) begin
        tests_failed++;
        $display("FAIL wrap_led1: got %b expected 1", led1);
      end
    end
    release_all("blink_release_d");
  endtask

  task automatic test_back_to_back();
    logic seen;
    do_reset();
    press_ch(1'b1, 1'b1, "both_press");
    tick();
    tests_run++;
    if ({mode1, mode2} !== 4'b0101) begin
      tests_failed++;
      $display("FAIL both_modes: got %0d/%0d expected 1/1", mode1, mode2);
    end
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (press1 || press2) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL held_no_repeat: pulse seen while held, expected none");
    end
    tests_run++;
    if ({mode1, mode2, led1, led2} !== 6'b0101_00) begin
      tests_failed++;
      $display("FAIL held_state: mode=%0d/%0d led=%b%b expected 1/1 led=00", mode1, mode2, led1, led2);
    end
    release_all("both_release");
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_ch(1'b1, 1'b0, "mid_press_a");
    release_all("mid_release_a");
    press_ch(1'b1, 1'b0, "mid_press_b");
    release_all("mid_release_b");
    press_ch(1'b1, 1'b0, "mid_press_c");
    tick();
    tests_run++;
    if (mode1 !== 2'd3) begin
      tests_failed++;
      $display("FAIL mid_pre_mode: got %0d expected 3", mode1);
    end
    repeat (2) tick();
    // switch1 still held low through the reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({led1, mode1, press1} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL mid_reset_state: led1=%b mode1=%0d press1=%b expected 1/0/0", led1, mode1, press1);
    end
    for (int i = 1; i <= 7; i++) begin
      tick();
      tests_run++;
      if (press1 !== (i == 6)) begin
        tests_failed++;
        $display("FAIL mid_held_press1 edge +%0d: got %b expected %b", i, press1, (i == 6));
      end
    end
    tests_run++;
    if (mode1 !== 2'd1) begin
      tests_failed++;
      $display("FAIL mid_held_mode1: got %0d expected 1", mode1);
    end
    release_all("mid_release_c");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    switch1      = 1'b1;
    switch2      = 1'b1;
    test_reset();
    test_press_latency();
    test_bounce();
    test_blink();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
